// File: rtl/fifo_rd_checker.sv
// Read-side consumer/checker for the MEDAC async FIFO: pops whenever non-empty and
// checks an incrementing pattern. Optional first-error capture under FIFO_CHK_FIRST_ERR_EN.
module fifo_rd_checker #(
  parameter int unsigned      DSIZE  = 40,
  parameter logic [31:0]      NWORDS = 32'd0,
  parameter logic [DSIZE-1:0] SEED   = {DSIZE{1'b0}}
) (
  input  logic             rclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rempty_n,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [31:0]      rd_cnt,
  output logic [31:0]      err_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef FIFO_CHK_FIRST_ERR_EN
  ,
  output logic [31:0]      first_err_idx,
  output logic [DSIZE-1:0] first_err_data,
  output logic [DSIZE-1:0] first_err_exp
`endif
);

  localparam int unsigned CW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             start_q;
  logic [DSIZE-1:0] exp_q, exp_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    err_cnt_q, err_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

`ifdef FIFO_CHK_FIRST_ERR_EN
  logic [CW-1:0]    fe_idx_q, fe_idx_d;
  logic [DSIZE-1:0] fe_data_q, fe_data_d;
  logic [DSIZE-1:0] fe_exp_q, fe_exp_d;
`endif

  logic start_rise_c;
  logic at_limit_c;
  logic pop_c;
  logic mismatch_c;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Pop strobe is combinational from registered state and the FIFO flag.
  always_comb begin
    start_rise_c = start & ~start_q;
    at_limit_c   = (NWORDS != 32'd0) && (rd_cnt_q == NWORDS);
    pop_c        = (state_q == S_RUN) && rempty_n && !at_limit_c;
    mismatch_c   = pop_c && (rdata != exp_q);
  end

  assign rinc = pop_c;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
`ifdef FIFO_CHK_FIRST_ERR_EN
    fe_idx_d  = fe_idx_q;
    fe_data_d = fe_data_q;
    fe_exp_d  = fe_exp_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise_c) begin
          state_d   = S_RUN;
          exp_d     = SEED;
          rd_cnt_d  = '0;
          err_cnt_d = '0;
`ifdef FIFO_CHK_FIRST_ERR_EN
          fe_idx_d  = '0;
          fe_data_d = '0;
          fe_exp_d  = '0;
`endif
        end else if ((state_q == S_DONE) && !start) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (pop_c) begin
          rd_cnt_d = sat_inc(rd_cnt_q);
          exp_d    = exp_q + DSIZE'(1);
          if (mismatch_c) begin
            err_cnt_d = sat_inc(err_cnt_q);
`ifdef FIFO_CHK_FIRST_ERR_EN
            if (err_cnt_q == '0) begin
              fe_idx_d  = rd_cnt_q;
              fe_data_d = rdata;
              fe_exp_d  = exp_q;
            end
`endif
          end
        end
        // A pop in the same cycle as start falling still counts.
        if (!start) begin
          state_d = S_IDLE;
        end else if (pop_c && (NWORDS != 32'd0) && (rd_cnt_d == NWORDS)) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      exp_q     <= SEED;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef FIFO_CHK_FIRST_ERR_EN
      fe_idx_q  <= '0;
      fe_data_q <= '0;
      fe_exp_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      exp_q     <= exp_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef FIFO_CHK_FIRST_ERR_EN
      fe_idx_q  <= fe_idx_d;
      fe_data_q <= fe_data_d;
      fe_exp_q  <= fe_exp_d;
`endif
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign err_cnt = err_cnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;

`ifdef FIFO_CHK_FIRST_ERR_EN
  assign first_err_idx  = fe_idx_q;
  assign first_err_data = fe_data_q;
  assign first_err_exp  = fe_exp_q;
`endif

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Scoreboard bench for fifo_rd_checker: three instances cover bounded, wrapping-seed
// and unbounded runs, each fed by a queue-based show-ahead FIFO model.
module tb_fifo_rd_checker;

  localparam int unsigned DW = 40;

  typedef struct {
    int          id;
    logic [31:0] rd;
    logic [31:0] er;
    logic        dn;
    logic        ps;
  } rec_t;

  logic          rclk;
  logic          rst_n;
  logic          start_s    [3];
  logic          rempty_n_s [3];
  logic [DW-1:0] rdata_s    [3];
  logic          rinc_s     [3];
  logic [31:0]   rd_cnt_s   [3];
  logic [31:0]   err_cnt_s  [3];
  logic          busy_s     [3];
  logic          done_s     [3];
  logic          pass_s     [3];
`ifdef FIFO_CHK_FIRST_ERR_EN
  logic [31:0]   fe_idx_s   [3];
  logic [DW-1:0] fe_data_s  [3];
  logic [DW-1:0] fe_exp_s   [3];
`endif

  logic [DW-1:0] q0[$], q1[$], q2[$];
  logic          gate [3];
  logic          tog  [3];
  logic          popped [3];
  logic          bprev [3];
  rec_t          sb[$];
  rec_t          r_mon;
  int            checks;
  int            errors;
  int            cyc;

  fifo_rd_checker #(.DSIZE(DW), .NWORDS(32'd16), .SEED(40'd0)) u_a (
    .rclk(rclk), .rst_n(rst_n), .start(start_s[0]), .rempty_n(rempty_n_s[0]),
    .rdata(rdata_s[0]), .rinc(rinc_s[0]), .rd_cnt(rd_cnt_s[0]), .err_cnt(err_cnt_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0])
`ifdef FIFO_CHK_FIRST_ERR_EN
    , .first_err_idx(fe_idx_s[0]), .first_err_data(fe_data_s[0]), .first_err_exp(fe_exp_s[0])
`endif
  );

  fifo_rd_checker #(.DSIZE(DW), .NWORDS(32'd4), .SEED(40'hFF_FFFF_FFFE)) u_b (
    .rclk(rclk), .rst_n(rst_n), .start(start_s[1]), .rempty_n(rempty_n_s[1]),
    .rdata(rdata_s[1]), .rinc(rinc_s[1]), .rd_cnt(rd_cnt_s[1]), .err_cnt(err_cnt_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1])
`ifdef FIFO_CHK_FIRST_ERR_EN
    , .first_err_idx(fe_idx_s[1]), .first_err_data(fe_data_s[1]), .first_err_exp(fe_exp_s[1])
`endif
  );

  fifo_rd_checker #(.DSIZE(DW), .NWORDS(32'd0), .SEED(40'd0)) u_c (
    .rclk(rclk), .rst_n(rst_n), .start(start_s[2]), .rempty_n(rempty_n_s[2]),
    .rdata(rdata_s[2]), .rinc(rinc_s[2]), .rd_cnt(rd_cnt_s[2]), .err_cnt(err_cnt_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2])
`ifdef FIFO_CHK_FIRST_ERR_EN
    , .first_err_idx(fe_idx_s[2]), .first_err_data(fe_data_s[2]), .first_err_exp(fe_exp_s[2])
`endif
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Show-ahead FIFO model: pop on a sampled rinc, then present the new head.
  always begin
    @(posedge rclk);
    for (int i = 0; i < 3; i++) popped[i] = rinc_s[i];
    #1;
    if (popped[0] && q0.size() != 0) q0.delete(0);
    if (popped[1] && q1.size() != 0) q1.delete(0);
    if (popped[2] && q2.size() != 0) q2.delete(0);
    for (int i = 0; i < 3; i++) gate[i] = tog[i] ? ~gate[i] : 1'b1;
    rempty_n_s[0] = gate[0] && (q0.size() != 0);
    rempty_n_s[1] = gate[1] && (q1.size() != 0);
    rempty_n_s[2] = gate[2] && (q2.size() != 0);
    rdata_s[0] = (q0.size() != 0) ? q0[0] : '0;
    rdata_s[1] = (q1.size() != 0) ? q1[0] : '0;
    rdata_s[2] = (q2.size() != 0) ? q2[0] : '0;
  end

  // Monitor: a run ending (busy falling) pops and checks the expected summary.
  always @(negedge rclk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_s[i] && !rempty_n_s[i])
        chk($sformatf("no_pop_empty_%0d", i), 64'(rinc_s[i]), 64'd0);
      if (bprev[i] && !busy_s[i]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_end: got run end on dut %0d expected none", i);
        end else begin
          r_mon = sb.pop_front();
          chk($sformatf("sb%0d_id", i),      64'(i),            64'(r_mon.id));
          chk($sformatf("sb%0d_rd_cnt", i),  64'(rd_cnt_s[i]),  64'(r_mon.rd));
          chk($sformatf("sb%0d_err_cnt", i), 64'(err_cnt_s[i]), 64'(r_mon.er));
          chk($sformatf("sb%0d_done", i),    64'(done_s[i]),    64'(r_mon.dn));
          chk($sformatf("sb%0d_pass", i),    64'(pass_s[i]),    64'(r_mon.ps));
        end
      end
      bprev[i] = busy_s[i];
    end
  end

  task automatic fill(input int id, input logic [DW-1:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] w;
      w = first + DW'(k);
      case (id)
        0:       q0.push_back(w);
        1:       q1.push_back(w);
        default: q2.push_back(w);
      endcase
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] rd, input logic [31:0] er,
                          input logic dn, input logic ps);
    rec_t r;
    r.id = id; r.rd = rd; r.er = er; r.dn = dn; r.ps = ps;
    sb.push_back(r);
  endtask

  task automatic wait_end(input int id, output int c);
    logic seen;
    c = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge rclk);
      if (done_s[id]) seen = 1'b1;
      else if (busy_s[id]) c++;
    end
    chk($sformatf("done_reached_%0d", id), 64'(seen), 64'd1);
  endtask

  task automatic wait_cnt(input int id, input logic [31:0] n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge rclk);
      if (rd_cnt_s[id] == n) seen = 1'b1;
    end
    chk($sformatf("cnt_reached_%0d", id), 64'(seen), 64'd1);
  endtask

  task automatic stop_run(input int id);
    start_s[id] = 1'b0;
    repeat (2) @(negedge rclk);
    chk($sformatf("idle_done_%0d", id), 64'(done_s[id]), 64'd0);
    chk($sformatf("idle_busy_%0d", id), 64'(busy_s[id]), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; tog[i] = 1'b0; gate[i] = 1'b1; bprev[i] = 1'b0;
      rempty_n_s[i] = 1'b0; rdata_s[i] = '0;
    end

    repeat (2) @(negedge rclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rinc_%0d", i),   64'(rinc_s[i]),    64'd0);
      chk($sformatf("rst_busy_%0d", i),   64'(busy_s[i]),    64'd0);
      chk($sformatf("rst_done_%0d", i),   64'(done_s[i]),    64'd0);
      chk($sformatf("rst_pass_%0d", i),   64'(pass_s[i]),    64'd0);
      chk($sformatf("rst_rd_cnt_%0d", i), 64'(rd_cnt_s[i]),  64'd0);
      chk($sformatf("rst_err_%0d", i),    64'(err_cnt_s[i]), 64'd0);
    end
    rst_n = 1'b1;

    // Clean 16-word run, FIFO never empty: 16 back-to-back pops.
    fill(0, 40'd0, 16);
    push_exp(0, 32'd16, 32'd0, 1'b1, 1'b1);
    @(negedge rclk);
    start_s[0] = 1'b1;
    wait_end(0, cyc);
    chk("t1_busy_cycles", 64'(cyc), 64'd16);
`ifdef FIFO_CHK_FIRST_ERR_EN
    chk("t1_fe_idx", 64'(fe_idx_s[0]), 64'd0);
`endif
    @(negedge rclk);
    chk("t1_done_hold", 64'(done_s[0]), 64'd1);
    chk("t1_no_pop_done", 64'(rinc_s[0]), 64'd0);
    stop_run(0);
    chk("t1_rd_cnt_held", 64'(rd_cnt_s[0]), 64'd16);

    // Word 5 corrupted to 0x5A.
    fill(0, 40'd0, 16);
    q0[5] = 40'h5A;
    push_exp(0, 32'd16, 32'd1, 1'b1, 1'b0);
    @(negedge rclk);
    start_s[0] = 1'b1;
    wait_end(0, cyc);
`ifdef FIFO_CHK_FIRST_ERR_EN
    chk("t2_fe_idx",  64'(fe_idx_s[0]),  64'd5);
    chk("t2_fe_data", 64'(fe_data_s[0]), 64'h5A);
    chk("t2_fe_exp",  64'(fe_exp_s[0]),  64'd5);
`endif
    stop_run(0);

    // rempty_n toggling every cycle.
    tog[0] = 1'b1;
    fill(0, 40'd0, 16);
    push_exp(0, 32'd16, 32'd0, 1'b1, 1'b1);
    @(negedge rclk);
    start_s[0] = 1'b1;
    wait_end(0, cyc);
    chk("t3_busy_stretched", 64'(cyc >= 30), 64'd1);
    tog[0] = 1'b0;
    stop_run(0);

    // Reset in the middle of a run, then a clean restart.
    fill(0, 40'd0, 16);
    @(negedge rclk);
    start_s[0] = 1'b1;
    wait_cnt(0, 32'd7);
    push_exp(0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rinc_async", 64'(rinc_s[0]),    64'd0);
    chk("t4_busy",       64'(busy_s[0]),    64'd0);
    chk("t4_rd_cnt",     64'(rd_cnt_s[0]),  64'd0);
    chk("t4_err_cnt",    64'(err_cnt_s[0]), 64'd0);
    start_s[0] = 1'b0;
    q0.delete();
    @(negedge rclk);
    chk("t4_rinc_in_rst", 64'(rinc_s[0]), 64'd0);
    rst_n = 1'b1;
    fill(0, 40'd0, 16);
    push_exp(0, 32'd16, 32'd0, 1'b1, 1'b1);
    @(negedge rclk);
    start_s[0] = 1'b1;
    wait_end(0, cyc);
    chk("t4_restart_cycles", 64'(cyc), 64'd16);
    stop_run(0);

    // Seed near the top of the range: expected value wraps through zero.
    fill(1, 40'hFF_FFFF_FFFE, 4);
    push_exp(1, 32'd4, 32'd0, 1'b1, 1'b1);
    @(negedge rclk);
    start_s[1] = 1'b1;
    wait_end(1, cyc);
    chk("t5_busy_cycles", 64'(cyc), 64'd4);
    stop_run(1);

    // Unbounded run stopped after 100 pops.
    fill(2, 40'd0, 100);
    push_exp(2, 32'd100, 32'd0, 1'b0, 1'b0);
    @(negedge rclk);
    start_s[2] = 1'b1;
    wait_cnt(2, 32'd100);
    start_s[2] = 1'b0;
    fill(2, 40'd100, 5);
    repeat (6) @(negedge rclk);
    chk("t6_rd_cnt_held", 64'(rd_cnt_s[2]),  64'd100);
    chk("t6_no_pop",      64'(rinc_s[2]),    64'd0);
    chk("t6_done",        64'(done_s[2]),    64'd0);
    chk("t6_err_cnt",     64'(err_cnt_s[2]), 64'd0);

    repeat (2) @(negedge rclk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
